irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: BASE_PORT, default 8'h20, low byte of the two-port I/O window (BASE_PORT, BASE_PORT+1).
REQ-002 clock  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 irq_src  in  8  interrupt sources, rising-edge sensitive; bit 0 = highest priority.
REQ-005 port_addr  in  8  CPU I/O port address (low byte).
REQ-006 port_we  in  1  port write strobe, one cycle.
REQ-007 port_rd  in  1  port read strobe, one cycle.
REQ-008 port_wdata  in  8  port write data.
REQ-009 port_rdata  out  8  registered port read data.
REQ-010 iff1  in  1  CPU interrupt-enable flag.
REQ-011 inta  in  1  interrupt-acknowledge strobe, one cycle.
REQ-012 int_req  out  1  interrupt request to the CPU.
REQ-013 vector  out  8  RST opcode for the acknowledged level.

Function
REQ-014 Edge detect: the block SHALL keep a 1-cycle-delayed copy of irq_src; for each bit, irq_src=1 with delayed=0 SHALL set the IRR bit the next cycle.
REQ-015 IRR latching SHALL ignore the mask; mask only gates eligibility.
REQ-016 Eligible level: the lowest-numbered n with IRR[n]=1 and MASK[n]=0, and n lower than the lowest set ISR bit (all levels if ISR=0).
REQ-017 States: IDLE, REQ, ACK.
REQ-018 IDLE->REQ when an eligible level exists and iff1=1; int_req=1 while in REQ.
REQ-019 REQ->IDLE, int_req=0 next cycle, if no eligible level exists or iff1=0, without inta.
REQ-020 REQ with inta=1 -> ACK: the eligible level n SHALL be re-evaluated in that cycle; vector SHALL become 8'hC7|(n<<3); ISR[n] set, IRR[n] cleared; int_req=0 from the next cycle.
REQ-021 If inta=1 with no eligible level, vector SHALL become 8'hFF (RST 7, spurious); ISR and IRR unchanged.
REQ-022 inta in IDLE or ACK SHALL be ignored.
REQ-023 ACK -> IDLE unconditionally after one cycle; vector SHALL hold until the next accepted inta.
REQ-024 Write BASE_PORT: MASK <= port_wdata (1 = masked).
REQ-025 Write BASE_PORT+1: port_wdata[7]=0 is a non-specific EOI that clears the lowest set ISR bit; port_wdata[7]=1 is a specific EOI that clears ISR[port_wdata[2:0]]; EOI with ISR=0 is a no-op.
REQ-026 Read BASE_PORT: port_rdata <= IRR next cycle; read BASE_PORT+1: port_rdata <= ISR; other addresses leave port_rdata unchanged.
REQ-027 Same cycle, IRR set by an edge and cleared by inta on the same level: the set SHALL win; IRR stays 1.
REQ-028 Same cycle, EOI and inta: EOI SHALL apply to the ISR value before that cycle, then the new ISR bit is set; both take effect.
REQ-029 Same cycle, mask write and an edge: the IRR bit SHALL latch; eligibility uses the new mask from the next cycle.
REQ-030 Reads SHALL have no side effects.

Reset
REQ-031 On reset_n=0, asynchronously: MASK=8'hFF, IRR=0, ISR=0, the delayed irq_src copy=8'hFF, state=IDLE, int_req=0, vector=8'hFF, port_rdata=0.
REQ-032 A source held high through reset release SHALL NOT latch until it falls and rises again.
REQ-033 Reset during REQ or ACK SHALL drop int_req immediately and discard any pending acknowledge.

Verification
REQ-034 Basic interrupt: MASK=8'hFD, iff1=1, pulse irq_src[1]; assert inta -> int_req=1 within 2 cycles; vector=8'hCF; ISR=8'h02; IRR=0.
REQ-035 Priority and nesting: MASK=0, edges on levels 3 and 5 in the same cycle, inta -> vector=8'hDF, ISR=8'h08. A second inta returns nothing eligible (level 5 is below the in-service level), so int_req stays 0. Non-specific EOI -> int_req=1; inta -> vector=8'hEF.
REQ-036 Spurious acknowledge: while in REQ for level 2, write MASK=8'hFF in the same cycle as inta -> vector=8'hD7. Retest with the mask write one cycle before inta -> int_req falls, and a later inta is ignored.
REQ-037 Simultaneous events: edge on level 4 in the same cycle as inta accepts level 4 -> ISR[4]=1 and IRR[4] remains 1. EOI in the same cycle as inta -> old ISR bit cleared and new bit set.
REQ-038 Masking and iff1: with iff1=0 and a pending unmasked level, int_req stays 0; raising iff1 gives int_req=1 the next cycle.
REQ-039 Reset behaviour: assert reset_n=0 while int_req=1 -> int_req=0 and vector=8'hFF at once. With irq_src[0] held high through release, no IRR set; then toggle the source low and high -> IRR=8'h01.

Source files
------------

// File: rtl/irq_ctrl.sv
// Eight-level priority interrupt controller: edge-latched requests, mask/ISR
// registers behind a two-port I/O window, and RST-opcode vector generation.
module irq_ctrl #(
  parameter logic [7:0] BASE_PORT = 8'h20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] irq_src,
  input  logic [7:0] port_addr,
  input  logic       port_we,
  input  logic       port_rd,
  input  logic [7:0] port_wdata,
  output logic [7:0] port_rdata,
  input  logic       iff1,
  input  logic       inta,
  output logic       int_req,
  output logic [7:0] vector
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t     state_q, state_d;
  logic [7:0] src_dly_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] vector_q, vector_d;
  logic [7:0] rdata_q, rdata_d;

  logic       sel_mask, sel_cmd;
  logic [7:0] isr_low, prio_win, cand;
  logic       elig_vld;
  logic [2:0] elig_idx;
  logic [7:0] isr_set, irr_clr, eoi_clr;

  assign sel_mask = (port_addr == BASE_PORT);
  assign sel_cmd  = (port_addr == (BASE_PORT + 8'd1));

  // Only levels strictly above the highest-priority in-service level may
  // request; isr_low-1 is all ones when nothing is in service.
  always_comb begin
    isr_low  = isr_q & (~isr_q + 8'd1);
    prio_win = isr_low - 8'd1;
    cand     = irr_q & ~mask_q & prio_win;
    elig_vld = |cand;
    elig_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) elig_idx = i[2:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    isr_set  = '0;
    irr_clr  = '0;
    case (state_q)
      S_IDLE: if (elig_vld && iff1) state_d = S_REQ;
      S_REQ: begin
        if (inta) begin
          state_d = S_ACK;
          if (elig_vld) begin
            vector_d = 8'hC7 | {2'b00, elig_idx, 3'b000};
            isr_set  = 8'd1 << elig_idx;
            irr_clr  = 8'd1 << elig_idx;
          end else begin
            vector_d = 8'hFF;
          end
        end else if (!elig_vld || !iff1) begin
          state_d = S_IDLE;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    eoi_clr = '0;
    if (port_we && sel_cmd) begin
      eoi_clr = port_wdata[7] ? (8'd1 << port_wdata[2:0]) : isr_low;
    end

    // A new edge on a level being acknowledged keeps its IRR bit set.
    isr_d  = (isr_q & ~eoi_clr) | isr_set;
    irr_d  = (irr_q & ~irr_clr) | (irq_src & ~src_dly_q);
    mask_d = (port_we && sel_mask) ? port_wdata : mask_q;

    rdata_d = rdata_q;
    if (port_rd && sel_mask)     rdata_d = irr_q;
    else if (port_rd && sel_cmd) rdata_d = isr_q;
  end

  // The delayed source copy resets high so a source held through reset
  // needs a fresh rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_dly_q <= 8'hFF;
      irr_q     <= '0;
      isr_q     <= '0;
      mask_q    <= 8'hFF;
      vector_q  <= 8'hFF;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_dly_q <= irq_src;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      mask_q    <= mask_d;
      vector_q  <= vector_d;
      rdata_q   <= rdata_d;
    end
  end

  assign int_req    = (state_q == S_REQ);
  assign vector     = vector_q;
  assign port_rdata = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: linear stimulus with hand-computed expectations
// checked by immediate assertions.
module tb_irq_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] irq_src;
  logic [7:0] port_addr;
  logic       port_we;
  logic       port_rd;
  logic [7:0] port_wdata;
  logic [7:0] port_rdata;
  logic       iff1;
  logic       inta;
  logic       int_req;
  logic [7:0] vector;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.BASE_PORT(8'h20)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .port_addr  (port_addr),
    .port_we    (port_we),
    .port_rd    (port_rd),
    .port_wdata (port_wdata),
    .port_rdata (port_rdata),
    .iff1       (iff1),
    .inta       (inta),
    .int_req    (int_req),
    .vector     (vector)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_addr  = addr;
    port_wdata = data;
    port_we    = 1'b1;
    tick();
    port_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_addr = addr;
    port_rd   = 1'b1;
    tick();
    port_rd   = 1'b0;
    chk(tag, port_rdata, exp);
  endtask

  task automatic pulse(input int lvl);
    irq_src[lvl] = 1'b1;
    tick();
    irq_src[lvl] = 1'b0;
  endtask

  task automatic ack();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (int_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(tag, {7'd0, int_req}, 8'h01);
  endtask

  initial begin
    reset_n    = 1'b0;
    irq_src    = '0;
    port_addr  = '0;
    port_we    = 1'b0;
    port_rd    = 1'b0;
    port_wdata = '0;
    iff1       = 1'b0;
    inta       = 1'b0;
    tick();
    tick();
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_vector", vector, 8'hFF);
    chk("rst_rdata", port_rdata, 8'h00);
    reset_n = 1'b1;
    tick();
    rd("rst_irr", 8'h20, 8'h00);
    rd("rst_isr", 8'h21, 8'h00);

    // Basic interrupt on level 1
    wr(8'h20, 8'hFD);
    iff1 = 1'b1;
    pulse(1);
    wait_int("basic_req");
    ack();
    chk("basic_vec", vector, 8'hCF);
    chk("basic_req_drop", {7'd0, int_req}, 8'h00);
    rd("basic_isr", 8'h21, 8'h02);
    rd("basic_irr", 8'h20, 8'h00);
    wr(8'h21, 8'h00);
    rd("basic_eoi", 8'h21, 8'h00);

    // Priority and nesting: levels 3 and 5 together
    wr(8'h20, 8'h00);
    irq_src = 8'h28;
    tick();
    irq_src = 8'h00;
    wait_int("prio_req");
    ack();
    chk("prio_vec3", vector, 8'hDF);
    rd("prio_isr3", 8'h21, 8'h08);
    tick();
    chk("nest_blocked", {7'd0, int_req}, 8'h00);
    ack();
    chk("nest_ign_vec", vector, 8'hDF);
    chk("nest_ign_req", {7'd0, int_req}, 8'h00);
    wr(8'h21, 8'h00);
    wait_int("nest_eoi_req");
    ack();
    chk("prio_vec5", vector, 8'hEF);
    rd("prio_isr5", 8'h21, 8'h20);
    wr(8'h21, 8'h00);
    rd("prio_irr", 8'h20, 8'h00);

    // Mask write in the same cycle as inta: old mask still decides
    pulse(2);
    wait_int("samecyc_req");
    port_addr  = 8'h20;
    port_wdata = 8'hFF;
    port_we    = 1'b1;
    inta       = 1'b1;
    tick();
    port_we    = 1'b0;
    inta       = 1'b0;
    chk("samecyc_vec", vector, 8'hD7);
    rd("samecyc_isr", 8'h21, 8'h04);
    wr(8'h21, 8'h00);

    // Mask write one cycle before inta: acknowledge becomes spurious
    wr(8'h20, 8'h00);
    pulse(2);
    wait_int("spur_req");
    wr(8'h20, 8'hFF);
    chk("spur_req_hold", {7'd0, int_req}, 8'h01);
    ack();
    chk("spur_vec", vector, 8'hFF);
    chk("spur_req_drop", {7'd0, int_req}, 8'h00);
    rd("spur_isr", 8'h21, 8'h00);
    rd("spur_irr", 8'h20, 8'h04);
    ack();
    chk("spur_late_ign", vector, 8'hFF);
    wr(8'h20, 8'h00);
    wait_int("spur_clean_req");
    ack();
    chk("spur_clean_vec", vector, 8'hD7);
    wr(8'h21, 8'h00);

    // Edge on the level being acknowledged: IRR bit stays set
    pulse(4);
    wait_int("edgeack_req");
    irq_src[4] = 1'b1;
    inta       = 1'b1;
    tick();
    irq_src[4] = 1'b0;
    inta       = 1'b0;
    chk("edgeack_vec", vector, 8'hE7);
    rd("edgeack_isr", 8'h21, 8'h10);
    rd("edgeack_irr", 8'h20, 8'h10);

    // EOI together with inta: old bit 4 cleared, new bit 1 set
    pulse(1);
    wait_int("eoiack_req");
    port_addr  = 8'h21;
    port_wdata = 8'h00;
    port_we    = 1'b1;
    inta       = 1'b1;
    tick();
    port_we    = 1'b0;
    inta       = 1'b0;
    chk("eoiack_vec", vector, 8'hCF);
    rd("eoiack_isr", 8'h21, 8'h02);
    rd("eoiack_irr", 8'h20, 8'h10);
    wr(8'h21, 8'h81);
    wait_int("spec_eoi_req");
    ack();
    chk("spec_eoi_vec", vector, 8'hE7);
    wr(8'h21, 8'h84);
    rd("spec_eoi_isr", 8'h21, 8'h00);
    wr(8'h21, 8'h00);
    rd("eoi_noop_isr", 8'h21, 8'h00);

    // iff1 gating
    iff1 = 1'b0;
    pulse(6);
    tick();
    tick();
    chk("iff1_block", {7'd0, int_req}, 8'h00);
    iff1 = 1'b1;
    tick();
    chk("iff1_raise", {7'd0, int_req}, 8'h01);
    iff1 = 1'b0;
    tick();
    chk("iff1_drop", {7'd0, int_req}, 8'h00);
    iff1 = 1'b1;
    tick();
    chk("iff1_reraise", {7'd0, int_req}, 8'h01);

    // Reset while requesting, then a source held through release
    reset_n = 1'b0;
    #1;
    chk("rst_async_req", {7'd0, int_req}, 8'h00);
    chk("rst_async_vec", vector, 8'hFF);
    chk("rst_async_rdata", port_rdata, 8'h00);
    irq_src[0] = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    rd("held_no_latch", 8'h20, 8'h00);
    irq_src[0] = 1'b0;
    tick();
    irq_src[0] = 1'b1;
    tick();
    tick();
    rd("held_relatch", 8'h20, 8'h01);
    chk("held_masked_req", {7'd0, int_req}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
